// File: rtl/ground_pkg.sv
// Shared constants and touch-state encoding for the ground block controller.
package ground_pkg;

  localparam int TILE_W_DEF   = 64;
  localparam int TILE_H_DEF   = 64;
  localparam int TICK_MAX_DEF = 6000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_TOUCHED = 2'd2
  } touch_state_t;

endpackage

// File: rtl/ground_touch_fsm.sv
// Per-block touch detector: two consecutive overlapping frame samples latch "touched"
// until a clear or reset.
module ground_touch_fsm
  import ground_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sample,
  input  logic overlap,
  output logic touched
);

  touch_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      touched <= 1'b0;
    end else if (clr) begin
      // A restart request wins over a coincident frame sample.
      state   <= ST_IDLE;
      touched <= 1'b0;
    end else if (sample) begin
      case (state)
        ST_IDLE: begin
          if (overlap) state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (overlap) begin
            state   <= ST_TOUCHED;
            touched <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_TOUCHED: state <= ST_TOUCHED;
        default: begin
          state   <= ST_IDLE;
          touched <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ground_ctrl.sv
// Ground block controller: animation tick, per-block touch tracking and the
// tile ROM address for the pixel under the beam.
module ground_ctrl
  import ground_pkg::*;
#(
  parameter int NUM_BLK  = 3,
  parameter int TILE_W   = TILE_W_DEF,
  parameter int TILE_H   = TILE_H_DEF,
  parameter int TICK_MAX = TICK_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  input  logic                  pix_valid,
  input  logic [9:0]            player_x,
  input  logic [9:0]            player_y,
  input  logic [9:0]            player_w,
  input  logic [9:0]            player_h,
  input  logic [10*NUM_BLK-1:0] blk_x,
  input  logic [10*NUM_BLK-1:0] blk_y,
  input  logic                  clr_touch,
  output logic [31:0]           ipcnt,
  output logic [11:0]           ground,
  output logic [NUM_BLK-1:0]    ground_hit,
  output logic [NUM_BLK-1:0]    bk_touched
);

  logic               frame_start;
  logic [10:0]        player_r;
  logic [10:0]        player_b;
  logic [NUM_BLK-1:0] overlap;
  logic [NUM_BLK-1:0] in_blk;
  logic [11:0]        addr_blk [NUM_BLK];
  logic [11:0]        sel_addr;
  logic [NUM_BLK-1:0] sel_hit;
  logic               found;

  assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign player_r    = {1'b0, player_x} + {1'b0, player_w};
  assign player_b    = {1'b0, player_y} + {1'b0, player_h};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ipcnt <= 32'd0;
    end else if (ipcnt >= 32'(TICK_MAX)) begin
      ipcnt <= 32'd0;
    end else begin
      ipcnt <= ipcnt + 32'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BLK; gi++) begin : g_blk
      logic [9:0]  bx;
      logic [9:0]  by;
      logic [10:0] bx_end;
      logic [10:0] by_end;
      logic [9:0]  dx;
      logic [9:0]  dy;

      assign bx     = blk_x[10*gi +: 10];
      assign by     = blk_y[10*gi +: 10];
      // 11-bit edges so a block near column/row 1023 does not wrap to 0.
      assign bx_end = {1'b0, bx} + 11'(TILE_W);
      assign by_end = {1'b0, by} + 11'(TILE_H);

      assign overlap[gi] = ({1'b0, player_x} <= bx_end) && ({1'b0, bx} <= player_r) &&
                           ({1'b0, player_y} <= by_end) && ({1'b0, by} <= player_b);

      assign in_blk[gi] = pix_valid &&
                          (h_cnt >= bx) && ({1'b0, h_cnt} < bx_end) &&
                          (v_cnt >= by) && ({1'b0, v_cnt} < by_end);

      assign dx = h_cnt - bx;
      assign dy = v_cnt - by;
      assign addr_blk[gi] = 12'(32'(dy) * 32'(TILE_W) + 32'(dx));

      ground_touch_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_touch),
        .sample  (frame_start),
        .overlap (overlap[gi]),
        .touched (bk_touched[gi])
      );
    end
  endgenerate

  // Lowest-index block under the beam wins when blocks overlap.
  always_comb begin
    sel_addr = '0;
    sel_hit  = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BLK; i++) begin
      if (!found && in_blk[i]) begin
        found      = 1'b1;
        sel_hit[i] = 1'b1;
        sel_addr   = addr_blk[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ground     <= 12'd0;
      ground_hit <= '0;
    end else begin
      ground     <= sel_addr;
      ground_hit <= sel_hit;
    end
  end

endmodule

// File: tb/tb_ground_ctrl.sv
// Randomized and directed checks of ground_ctrl against a frame-level behavioural model.
module tb_ground_ctrl;

  localparam int NB   = 3;
  localparam int TW   = 64;
  localparam int TH   = 64;
  localparam int TMAX = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    h_cnt = '0, v_cnt = 10'd5;
  logic          pix_valid = 1'b0;
  logic [9:0]    player_x = '0, player_y = '0, player_w = 10'd16, player_h = 10'd16;
  logic [29:0]   blk_x = '0, blk_y = '0;
  logic          clr_touch = 1'b0;
  logic [31:0]   ipcnt;
  logic [11:0]   ground;
  logic [NB-1:0] ground_hit;
  logic [NB-1:0] bk_touched;

  int checks = 0;
  int errors = 0;

  // Model state: ticks since reset, consecutive overlapping frame count, sticky touch.
  int          m_tick;
  int          m_streak [NB];
  bit [NB-1:0] m_touched;
  int          e_ground;
  bit [NB-1:0] e_hit;

  ground_ctrl #(.NUM_BLK(NB), .TILE_W(TW), .TILE_H(TH), .TICK_MAX(TMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pix_valid  (pix_valid),
    .player_x   (player_x),
    .player_y   (player_y),
    .player_w   (player_w),
    .player_h   (player_h),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .clr_touch  (clr_touch),
    .ipcnt      (ipcnt),
    .ground     (ground),
    .ground_hit (ground_hit),
    .bk_touched (bk_touched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bx(input int i); return int'(blk_x[10*i +: 10]); endfunction
  function automatic int by(input int i); return int'(blk_y[10*i +: 10]); endfunction

  function automatic bit touches(input int i);
    int px = int'(player_x), py = int'(player_y);
    return (px <= bx(i) + TW) && (bx(i) <= px + int'(player_w)) &&
           (py <= by(i) + TH) && (by(i) <= py + int'(player_h));
  endfunction

  task automatic model_reset();
    m_tick = 0;
    m_touched = '0;
    e_ground = 0;
    e_hit = '0;
    for (int i = 0; i < NB; i++) m_streak[i] = 0;
  endtask

  // Advance the model by one clock using the inputs as they stand, then compare.
  task automatic cycle();
    int h = int'(h_cnt), v = int'(v_cnt);
    e_ground = 0;
    e_hit = '0;
    for (int i = 0; i < NB; i++) begin
      if (pix_valid && h >= bx(i) && h < bx(i) + TW && v >= by(i) && v < by(i) + TH) begin
        e_ground = ((v - by(i)) * TW + (h - bx(i))) % 4096;
        e_hit[i] = 1'b1;
        break;
      end
    end
    if (clr_touch) begin
      for (int i = 0; i < NB; i++) m_streak[i] = 0;
      m_touched = '0;
    end else if (h == 0 && v == 0) begin
      for (int i = 0; i < NB; i++) begin
        m_streak[i] = touches(i) ? m_streak[i] + 1 : 0;
        if (m_streak[i] >= 2) m_touched[i] = 1'b1;
      end
    end
    m_tick = (m_tick + 1) % (TMAX + 1);
    @(posedge clk);
    #1;
    check("ipcnt", ipcnt, 32'(m_tick));
    check("ground", 32'(ground), 32'(e_ground));
    check("ground_hit", 32'(ground_hit), 32'(e_hit));
    check("bk_touched", 32'(bk_touched), 32'(m_touched));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ipcnt", ipcnt, 32'd0);
    check("rst_ground", 32'(ground), 32'd0);
    check("rst_hit", 32'(ground_hit), 32'd0);
    check("rst_touched", 32'(bk_touched), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input bit clr);
    h_cnt = '0; v_cnt = '0; clr_touch = clr;
    cycle();
    h_cnt = 10'd10; v_cnt = 10'd5; clr_touch = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    $display("reset released, tick check");

    begin
      int nines = 0;
      for (int c = 0; c < 25; c++) begin
        cycle();
        if (ipcnt == 32'd9) begin
          nines++;
          cycle();
          check("tick_wrap", ipcnt, 32'd0);
        end
      end
      check("tick_periods", 32'(nines), 32'd2);
    end

    blk_x = {10'd600, 10'd700, 10'd100};
    blk_y = {10'd400, 10'd400, 10'd50};
    h_cnt = 10'd105; v_cnt = 10'd52; pix_valid = 1'b1;
    cycle();
    check("addr_133", 32'(ground), 32'd133);
    check("addr_hit", 32'(ground_hit), 32'd1);
    $display("pixel (105,52) -> ground %0d hit %b", ground, ground_hit);

    blk_x = {10'd600, 10'd200, 10'd200};
    blk_y = {10'd400, 10'd200, 10'd200};
    h_cnt = 10'd210; v_cnt = 10'd210;
    cycle();
    check("overlap_hit", 32'(ground_hit), 32'd1);
    check("overlap_addr", 32'(ground), 32'd650);
    pix_valid = 1'b0;
    cycle();
    check("blank_addr", 32'(ground), 32'd0);
    check("blank_hit", 32'(ground_hit), 32'd0);
    $display("overlapping blocks and blanking checked");

    blk_x = {10'd50, 10'd500, 10'd300};
    blk_y = {10'd400, 10'd100, 10'd300};
    player_x = 10'd310; player_y = 10'd260; player_w = 10'd20; player_h = 10'd50;
    frame(1'b0);
    check("touch_armed", 32'(bk_touched), 32'd0);
    frame(1'b0);
    check("touch_set", 32'(bk_touched), 32'd1);
    player_x = 10'd700;
    frame(1'b0);
    frame(1'b0);
    check("touch_sticky", 32'(bk_touched), 32'd1);
    $display("two-frame touch on blk0 -> %b", bk_touched);

    frame(1'b1);
    check("clr_touch", 32'(bk_touched), 32'd0);
    player_x = 10'd510; player_y = 10'd90;
    frame(1'b0);
    player_x = 10'd900;
    frame(1'b0);
    check("arm_then_idle", 32'(bk_touched), 32'd0);
    player_x = 10'd510;
    frame(1'b0);
    frame(1'b1);
    check("clr_beats_sample", 32'(bk_touched), 32'd0);
    frame(1'b0);
    check("clr_rearm", 32'(bk_touched), 32'd0);
    frame(1'b0);
    check("retouch", 32'(bk_touched), 32'd2);
    $display("arm/idle and clear priority checked");

    do_reset();
    frame(1'b0);
    do_reset();
    frame(1'b0);
    check("rst_discards_arm", 32'(bk_touched), 32'd0);
    frame(1'b0);
    check("touch_after_rst", 32'(bk_touched), 32'd2);
    $display("reset during armed and touched checked");

    for (int n = 0; n < 1500; n++) begin
      int k;
      if (n % 100 == 0) begin
        for (int i = 0; i < NB; i++) begin
          blk_x[10*i +: 10] = 10'($urandom_range(0, 700));
          blk_y[10*i +: 10] = 10'($urandom_range(0, 460));
        end
      end
      k = $urandom_range(0, NB - 1);
      if ($urandom_range(0, 3) != 0) begin
        player_x = 10'(bx(k) + $urandom_range(0, 80) - 30);
        player_y = 10'(by(k) + $urandom_range(0, 80) - 30);
      end
      player_w = 10'($urandom_range(0, 40));
      player_h = 10'($urandom_range(0, 40));
      if ($urandom_range(0, 4) == 0) begin
        h_cnt = '0; v_cnt = '0;
      end else begin
        h_cnt = 10'(bx(k) + $urandom_range(0, 70) - 3);
        v_cnt = 10'(by(k) + $urandom_range(0, 70) - 3);
      end
      pix_valid = ($urandom_range(0, 5) != 0);
      clr_touch = ($urandom_range(0, 40) == 0);
      cycle();
    end
    clr_touch = 1'b0;
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ground_ctrl.md
GROUND_CTRL -- requirements
Module: ground_ctrl

Interface
REQ-001 SHALL have parameter NUM_BLK, default 3, the number of ground blocks.
REQ-002 SHALL have parameter TILE_W, default 64, the block width in pixels (power of two).
REQ-003 SHALL have parameter TILE_H, default 64, the block height in pixels.
REQ-004 SHALL have parameter TICK_MAX, default 6000000, the animation tick terminal count.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock. All logic runs on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port h_cnt, input, 10 bits: the current VGA pixel column.
REQ-008 SHALL have port v_cnt, input, 10 bits: the current VGA pixel row.
REQ-009 SHALL have port pix_valid, input, 1 bit: high when the pixel is in the visible area.
REQ-010 SHALL have ports player_x and player_y, input, 10 bits each: the player top-left corner.
REQ-011 SHALL have ports player_w and player_h, input, 10 bits each: the player size.
REQ-012 SHALL have ports blk_x and blk_y, input, 10*NUM_BLK bits each: the block top-left corners; block i uses bits [10i+9:10i].
REQ-013 SHALL have port clr_touch, input, 1 bit: a synchronous clear of all touch state (for a level restart).
REQ-014 SHALL have port ipcnt, output, 32 bits: the free-running animation tick counter.
REQ-015 SHALL have port ground, output, 12 bits: the ROM pixel address for the block under the beam.
REQ-016 SHALL have port ground_hit, output, NUM_BLK bits: a one-hot flag for the block under the beam.
REQ-017 SHALL have port bk_touched, output, NUM_BLK bits: a sticky per-block touched flag.

Function
REQ-018 SHALL count ipcnt 0,1,...,TICK_MAX, then return to 0 on the next cycle, so ipcnt==TICK_MAX holds for exactly one cycle per period.
REQ-019 SHALL define frame_start as h_cnt==0 && v_cnt==0. It SHALL be sampled once per frame and SHALL be the only touch sampling point.
REQ-020 SHALL compute overlap[i] as the inclusive bounding-box test between the player rectangle and the block i rectangle, using 11-bit sums so nothing wraps at 1023.
REQ-021 SHALL run one FSM per block with states IDLE, ARMED and TOUCHED:
- IDLE -> ARMED when overlap is true at frame_start.
- ARMED -> TOUCHED when overlap is true at the next frame_start.
- ARMED -> IDLE when overlap is false at frame_start.
- TOUCHED holds until clr_touch.
REQ-022 SHALL drive bk_touched[i] high only in TOUCHED. Its registered rise SHALL occur on the cycle after the confirming frame_start.
REQ-023 SHALL give clr_touch priority over frame_start when both occur in the same cycle: every FSM goes to IDLE.
REQ-024 SHALL evaluate the address path each cycle:
- in[i] = pix_valid && blk_x[i] <= h_cnt < blk_x[i]+TILE_W && blk_y[i] <= v_cnt < blk_y[i]+TILE_H.
- Select the lowest-index block i with in[i] true.
REQ-025 SHALL register ground = ((v_cnt-blk_y[i]) * TILE_W + (h_cnt-blk_x[i])) truncated to 12 bits, and register ground_hit as one-hot i. Latency SHALL be 1 cycle.
REQ-026 SHALL register ground=0 and ground_hit=0 when no block contains the pixel, including when pix_valid is low.
REQ-027 SHALL keep overlapping blocks one-hot in ground_hit, with the lowest index winning.

Reset
REQ-028 SHALL, while rst is high, force ipcnt=0, ground=0, ground_hit=0, bk_touched=0 and every FSM to IDLE, asynchronously.
REQ-029 SHALL, when rst is asserted mid-frame or mid-ARMED, discard the pending arm; touch detection restarts from the next frame_start after release.

Structure
REQ-030 SHALL place the TILE_W, TILE_H and TICK_MAX defaults and the FSM state encodings (IDLE=0, ARMED=1, TOUCHED=2) in the shared package ground_pkg.
REQ-031 SHALL implement the per-block FSM as sub-module ground_touch_fsm (clk, rst, clr, sample, overlap -> touched), instantiated NUM_BLK times by a generate loop.

Verification
REQ-032 SHALL cover: TICK_MAX=9 -> ipcnt runs 0..9,0; value 9 lasts one cycle; period is 10 cycles.
REQ-033 SHALL cover: player overlapping blk0 for two frame_starts -> bk_touched=3'b001 one cycle after the second frame_start; it stays set over later frames without overlap.
REQ-034 SHALL cover: overlap on one frame_start only, then none -> ARMED then IDLE; bk_touched stays 0.
REQ-035 SHALL cover: blk_x[0]=100, blk_y[0]=50, h_cnt=105, v_cnt=52, pix_valid=1 -> next cycle ground=133 (2*64+5), ground_hit=001.
REQ-036 SHALL cover: blk0 and blk1 both at (200,200), pixel (210,210) -> ground_hit=001. With pix_valid=0 -> ground=0, ground_hit=000.
REQ-037 SHALL cover: clr_touch coinciding with a confirming frame_start -> bk_touched stays 0. rst pulse while TOUCHED -> all outputs 0 immediately, without waiting for a clock edge.
